// File: rtl/miller_rx_deframer_pkg.sv
// Shared definitions for the Miller receive deframer and its timer.
//  - state_e             : deframer state codes (HUNT searches, LOCK packs payload)
//  - SYNC_WORD_DEFAULT   : frame delimiter, also used by the transmit-side framer
//  - shift_in()          : MSB-first shift of one decoded bit into the sync register
package miller_rx_deframer_pkg;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    localparam logic [7:0]  SYNC_WORD_DEFAULT = 8'hA5;
    localparam int unsigned FRAME_LEN_DEFAULT = 16;
    localparam int unsigned TIMEOUT_DEFAULT   = 1023;

    // Window seen after shifting bit b in below the 7 most recent bits.
    function automatic logic [7:0] shift_in(input logic [6:0] sr, input logic b);
        return {sr, b};
    endfunction

endpackage

// File: rtl/miller_rx_deframer_if.sv
// Receive-side bus of the deframer.
//  master : upstream decoder / consumer view (drives bits, observes bytes and flags)
//  slave  : deframer view (consumes bits, drives bytes and flags)
//  Bit_in/Bit_in_valid             decoded bit stream
//  data_out/data_out_valid         assembled payload byte and its strobe
//  frame_start/frame_end/frame_err framing event pulses
//  locked                          level, high while inside a frame
interface miller_rx_deframer_if;
    import miller_rx_deframer_pkg::*;

    logic       Bit_in;
    logic       Bit_in_valid;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       frame_start;
    logic       frame_end;
    logic       frame_err;
    logic       locked;

    modport master (
        output Bit_in, Bit_in_valid,
        input  data_out, data_out_valid, frame_start, frame_end, frame_err, locked
    );

    modport slave (
        input  Bit_in, Bit_in_valid,
        output data_out, data_out_valid, frame_start, frame_end, frame_err, locked
    );

endinterface

// File: rtl/miller_gap_timer.sv
// Bit-gap timer: counts idle cycles while enabled and flags the cycle in which the
// TIMEOUT-th consecutive idle cycle occurs.
//  clk, rst_p : clock, synchronous active-high reset
//  clear      : force the count to 0 (strobe seen, or not inside a frame)
//  enable     : an idle cycle inside a frame
//  expire_c   : combinational, high in the TIMEOUT-th idle cycle
module miller_gap_timer #(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic clk,
    input  logic rst_p,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    localparam int unsigned GAP_W = $clog2(TIMEOUT + 1);

    logic [GAP_W-1:0] gap_cnt_q;
    logic [GAP_W-1:0] gap_cnt_d;

    assign expire_c = enable && !clear && (gap_cnt_q == GAP_W'(TIMEOUT - 1));

    // Saturating idle counter; restarts from 0 after an expiry.
    always_comb begin
        gap_cnt_d = gap_cnt_q;
        if (clear || expire_c) begin
            gap_cnt_d = '0;
        end else if (enable && (gap_cnt_q != GAP_W'(TIMEOUT))) begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end

endmodule

// File: rtl/miller_rx_deframer.sv
// Miller receive deframer: hunts for SYNC_WORD in the decoded bit stream, then packs
// the following FRAME_LEN bytes MSB-first. A frame is aborted after TIMEOUT idle
// cycles without a bit strobe.
//  clk, rst_p : clock, synchronous active-high reset
//  rx (slave) : Bit_in/Bit_in_valid in; data_out, data_out_valid, frame_start,
//               frame_end, frame_err, locked out (all registered)
module miller_rx_deframer
    import miller_rx_deframer_pkg::*;
#(
    parameter logic [7:0]  SYNC_WORD = SYNC_WORD_DEFAULT,
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEFAULT,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_p,
    miller_rx_deframer_if.slave  rx
);

    state_e     state_q,     state_d;
    logic [6:0] sr_q,        sr_d;       // only the 7 newest bits feed the next window
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic [7:0] byte_cnt_q,  byte_cnt_d;
    logic [7:0] data_out_q,  data_out_d;
    logic       dv_q,        dv_d;
    logic       fs_q,        fs_d;
    logic       fe_q,        fe_d;
    logic       err_q,       err_d;
    logic       locked_q,    locked_d;

    logic [7:0] nxt;
    logic       gap_clear_c;
    logic       gap_enable_c;
    logic       gap_expire_c;

    // Idle cycles only count inside a frame; any strobe restarts the gap.
    assign gap_clear_c  = (state_q != ST_LOCK) || rx.Bit_in_valid;
    assign gap_enable_c = (state_q == ST_LOCK) && !rx.Bit_in_valid;

    miller_gap_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_gap_timer (
        .clk      (clk),
        .rst_p    (rst_p),
        .clear    (gap_clear_c),
        .enable   (gap_enable_c),
        .expire_c (gap_expire_c)
    );

    // Next-state and output computation.
    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        data_out_d = data_out_q;
        dv_d       = 1'b0;
        fs_d       = 1'b0;
        fe_d       = 1'b0;
        err_d      = 1'b0;

        nxt = shift_in(sr_q, rx.Bit_in);

        if (rx.Bit_in_valid) begin
            sr_d = nxt[6:0];
        end

        case (state_q)
            ST_HUNT: begin
                if (rx.Bit_in_valid && (nxt == SYNC_WORD)) begin
                    state_d    = ST_LOCK;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 8'd0;
                    fs_d       = 1'b1;
                end
            end
            ST_LOCK: begin
                if (rx.Bit_in_valid) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        data_out_d = nxt;
                        dv_d       = 1'b1;
                        byte_cnt_d = byte_cnt_q + 8'd1;
                        // Last payload byte: close the frame and demand 8 fresh sync bits.
                        if (byte_cnt_q == 8'(FRAME_LEN - 1)) begin
                            fe_d       = 1'b1;
                            state_d    = ST_HUNT;
                            sr_d       = 7'd0;
                            byte_cnt_d = 8'd0;
                        end
                    end
                end else if (gap_expire_c) begin
                    // Abort: partial byte is dropped silently.
                    err_d      = 1'b1;
                    state_d    = ST_HUNT;
                    sr_d       = 7'd0;
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 8'd0;
                end
            end
        endcase

        locked_d = (state_d == ST_LOCK);
    end

    always_ff @(posedge clk) begin
        if (rst_p) begin
            state_q    <= ST_HUNT;
            sr_q       <= 7'd0;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 8'd0;
            data_out_q <= 8'd0;
            dv_q       <= 1'b0;
            fs_q       <= 1'b0;
            fe_q       <= 1'b0;
            err_q      <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            data_out_q <= data_out_d;
            dv_q       <= dv_d;
            fs_q       <= fs_d;
            fe_q       <= fe_d;
            err_q      <= err_d;
            locked_q   <= locked_d;
        end
    end

    assign rx.data_out       = data_out_q;
    assign rx.data_out_valid = dv_q;
    assign rx.frame_start    = fs_q;
    assign rx.frame_end      = fe_q;
    assign rx.frame_err      = err_q;
    assign rx.locked         = locked_q;

endmodule

// File: tb/tb_miller_rx_deframer.sv
// Directed bench for miller_rx_deframer: per-cycle vector table on a FRAME_LEN=2,
// TIMEOUT=8 instance, plus a hand-written frame on a FRAME_LEN=3 instance.
module tb_miller_rx_deframer;

    logic clk = 1'b0;
    logic rst_p;

    always #5 clk = ~clk;

    miller_rx_deframer_if if2 ();
    miller_rx_deframer_if if3 ();

    miller_rx_deframer #(.SYNC_WORD(8'hA5), .FRAME_LEN(2), .TIMEOUT(8)) dut2 (
        .clk(clk), .rst_p(rst_p), .rx(if2.slave)
    );

    miller_rx_deframer #(.SYNC_WORD(8'hA5), .FRAME_LEN(3), .TIMEOUT(8)) dut3 (
        .clk(clk), .rst_p(rst_p), .rx(if3.slave)
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic       b;
        logic       dv;
        logic       chk;    // compare data_out on this vector
        logic [7:0] data;
        logic       fs;
        logic       fe;
        logic       err;
        logic       lk;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic push(input logic rst, input logic vld, input logic b, input logic dv,
                        input logic chk, input logic [7:0] data, input logic fs,
                        input logic fe, input logic err, input logic lk);
        vec_t v;
        v.rst = rst; v.vld = vld; v.b = b; v.dv = dv; v.chk = chk; v.data = data;
        v.fs = fs; v.fe = fe; v.err = err; v.lk = lk;
        vq.push_back(v);
    endtask

    task automatic push_rst();
        push(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input logic lk);
        for (int i = 0; i < n; i++)
            push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, lk);
    endtask

    task automatic bit1(input logic b, input logic lk);
        push(1'b0, 1'b1, b, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, lk);
    endtask

    // One byte MSB-first, `gap` idle cycles before every strobe; events land on the LSB.
    task automatic send_byte(input logic [7:0] byt, input int gap, input logic lk_mid,
                             input logic fs, input logic dv, input logic fe,
                             input logic lk_end);
        for (int i = 7; i >= 0; i--) begin
            idle(gap, lk_mid);
            if (i == 0) push(1'b0, 1'b1, byt[0], dv, dv, byt, fs, fe, 1'b0, lk_end);
            else        bit1(byt[i], lk_mid);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    logic [31:0] s3;
    int          fs_cnt, fs_at, fe_cnt, fe_at, dv_last;
    logic        lk_mid3, lk_end3;
    logic [7:0]  got[$];
    logic [4:0]  fa, fx;

    initial begin
        rst_p = 1'b1;
        if2.Bit_in = 1'b0; if2.Bit_in_valid = 1'b0;
        if3.Bit_in = 1'b0; if3.Bit_in_valid = 1'b0;

        // 1: sync + 3C + C3, one strobe per cycle; data_out holds after frame end
        push_rst();
        send_byte(8'hA5, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        send_byte(8'h3C, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        send_byte(8'hC3, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
        // 6: reset mid-byte in LOCK; leftover bits ignored until a fresh A5
        send_byte(8'hA5, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        bit1(1'b0, 1'b1); bit1(1'b0, 1'b1); bit1(1'b1, 1'b1); bit1(1'b1, 1'b1);
        push_rst();
        bit1(1'b1, 1'b0); bit1(1'b1, 1'b0); bit1(1'b0, 1'b0); bit1(1'b0, 1'b0);
        send_byte(8'hA5, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        // 2: noise 1,1,0 then A5, strobe every 4 cycles
        push_rst();
        idle(3, 1'b0); bit1(1'b1, 1'b0);
        idle(3, 1'b0); bit1(1'b1, 1'b0);
        idle(3, 1'b0); bit1(1'b0, 1'b0);
        send_byte(8'hA5, 3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        // 4: 3 payload bits then idle; abort on the 8th idle cycle, then relock
        bit1(1'b1, 1'b1); bit1(1'b0, 1'b1); bit1(1'b1, 1'b1);
        idle(7, 1'b1);
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b0);
        send_byte(8'hA5, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        // 5: 7 idle cycles before every strobe never aborts; HUNT never times out
        send_byte(8'h5A, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        send_byte(8'h81, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(10, 1'b0);

        for (int k = 0; k < vq.size(); k++) begin
            @(negedge clk);
            rst_p            = vq[k].rst;
            if2.Bit_in       = vq[k].b;
            if2.Bit_in_valid = vq[k].vld;
            @(posedge clk);
            #1;
            fa = {if2.data_out_valid, if2.frame_start, if2.frame_end, if2.frame_err, if2.locked};
            fx = {vq[k].dv, vq[k].fs, vq[k].fe, vq[k].err, vq[k].lk};
            n_vec++;
            if (fa !== fx || (vq[k].chk && if2.data_out !== vq[k].data)) begin
                n_bad++;
                $display("FAIL vec[%0d] flags(dv,fs,fe,err,lk) got %b want %b, data got %h want %h",
                         k, fa, fx, if2.data_out, vq[k].chk ? vq[k].data : if2.data_out);
            end
        end

        // 3: FRAME_LEN=3 frame carrying A5,00,FF -- payload A5 is data, not a re-sync
        @(negedge clk);
        if2.Bit_in_valid = 1'b0;
        rst_p = 1'b1;
        @(negedge clk);
        rst_p = 1'b0;
        s3 = 32'hA5A5_00FF;
        fs_cnt = 0; fs_at = -1; fe_cnt = 0; fe_at = -1; dv_last = -1;
        lk_mid3 = 1'b0; lk_end3 = 1'b1;
        for (int c = 0; c < 34; c++) begin
            if (c > 0) @(negedge clk);
            if (c < 32) begin
                if3.Bit_in       = s3[31-c];
                if3.Bit_in_valid = 1'b1;
            end else begin
                if3.Bit_in       = 1'b0;
                if3.Bit_in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (if3.frame_start) begin fs_cnt++; fs_at = c; end
            if (if3.frame_end)   begin fe_cnt++; fe_at = c; end
            if (if3.data_out_valid) begin got.push_back(if3.data_out); dv_last = c; end
            if (c == 20) lk_mid3 = if3.locked;
            if (c == 33) lk_end3 = if3.locked;
        end
        chk("f3_start_count", fs_cnt, 1);
        chk("f3_start_cycle", fs_at, 7);
        chk("f3_byte_count", got.size(), 3);
        chk("f3_byte0", (got.size() > 0) ? int'(got[0]) : -1, 32'hA5);
        chk("f3_byte1", (got.size() > 1) ? int'(got[1]) : -1, 32'h00);
        chk("f3_byte2", (got.size() > 2) ? int'(got[2]) : -1, 32'hFF);
        chk("f3_last_byte_cycle", dv_last, 31);
        chk("f3_end_count", fe_cnt, 1);
        chk("f3_end_cycle", fe_at, 31);
        chk("f3_locked_mid", int'(lk_mid3), 1);
        chk("f3_locked_after", int'(lk_end3), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
